// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point datapath blocks: mode encoding,
// saturation bounds and the round-half-up constant.
package fxp_pkg;

    localparam logic FXP_MUL = 1'b0;
    localparam logic FXP_MAC = 1'b1;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    function automatic longint round_const(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up of a full-width product, addend accumulation
// and saturation back to WIDTH bits.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 7
) (
    input  logic signed [2*WIDTH-1:0] prod,
    input  logic signed [WIDTH-1:0]   addend,
    output logic signed [WIDTH-1:0]   result,
    output logic                      ovf
);

    localparam int PW = 2 * WIDTH;
    // One guard bit over the rounded product so adding the addend can never wrap
    localparam int SW = PW - FRAC + 1;

    localparam logic signed [SW-1:0] S_MAX  = SW'(sat_max(WIDTH));
    localparam logic signed [SW-1:0] S_MIN  = SW'(sat_min(WIDTH));
    localparam logic signed [PW:0]   R_HALF = (PW+1)'(round_const(FRAC));

    function automatic logic signed [SW-1:0] round_prod(input logic signed [PW-1:0] p);
        logic signed [PW:0] t;
        t = (PW+1)'(p) + R_HALF;
        return SW'(t >>> FRAC);
    endfunction

    function automatic logic [WIDTH:0] saturate(input logic signed [SW-1:0] s);
        logic [WIDTH:0] r;
        if (s > S_MAX) begin
            r = {1'b1, WIDTH'(S_MAX)};
        end else if (s < S_MIN) begin
            r = {1'b1, WIDTH'(S_MIN)};
        end else begin
            r = {1'b0, s[WIDTH-1:0]};
        end
        return r;
    endfunction

    logic signed [SW-1:0] sum;

    always_comb begin
        sum           = round_prod(prod) + SW'(addend);
        {ovf, result} = saturate(sum);
    end

endmodule

// File: rtl/fixed_point_mac_pipe.sv
// Three-stage signed fixed-point multiply / multiply-accumulate with
// valid/ready handshakes, per-result overflow flag and sticky overflow status.
module fixed_point_mac_pipe
    import fxp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic signed [WIDTH-1:0] in_addend,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_result,
    output logic                    out_ovf,
    output logic                    ovf_sticky,
    input  logic                    ovf_clear
);

    localparam int PW = 2 * WIDTH;

    logic                    vld_p1, vld_p2;
    logic signed [WIDTH-1:0] a_p1, b_p1, add_p1, add_p2;
    logic signed [PW-1:0]    prod_p2;
    logic signed [WIDTH-1:0] res_p3;
    logic                    ovf_p3;
    logic                    load_p1, load_p2, load_p3;

    // A stage may load when it is empty or its current content moves on
    assign load_p3  = out_ready | ~out_valid;
    assign load_p2  = ~vld_p2 | load_p3;
    assign load_p1  = ~vld_p1 | load_p2;
    assign in_ready = load_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (load_p1) vld_p1 <= in_valid;
            if (load_p2) vld_p2 <= vld_p1;
            if (load_p3) begin
                out_valid <= vld_p2;
                if (vld_p2) begin
                    out_result <= res_p3;
                    out_ovf    <= ovf_p3;
                end
            end
            if (ovf_clear) begin
                ovf_sticky <= 1'b0;
            end else if (out_valid && out_ready && out_ovf) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

    // S1: operand capture; a MUL beat carries a zero addend downstream
    always_ff @(posedge clk) begin
        if (load_p1 && in_valid) begin
            a_p1   <= in_a;
            b_p1   <= in_b;
            add_p1 <= (in_mode == FXP_MAC) ? in_addend : '0;
        end
    end

    // S2: full-width product
    always_ff @(posedge clk) begin
        if (load_p2 && vld_p1) begin
            prod_p2 <= PW'(a_p1) * PW'(b_p1);
            add_p2  <= add_p1;
        end
    end

    // S3: round, accumulate and saturate feeding the output register
    fxp_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .prod   (prod_p2),
        .addend (add_p2),
        .result (res_p3),
        .ovf    (ovf_p3)
    );

endmodule

// File: tb/tb_fixed_point_mac_pipe.sv
// Directed bench for fixed_point_mac_pipe at WIDTH=16, FRAC=7 (1.0 = 128).
module tb_fixed_point_mac_pipe;

    localparam int W = 16;
    localparam int F = 7;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic signed [W-1:0] in_a;
    logic signed [W-1:0] in_b;
    logic signed [W-1:0] in_addend;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_result;
    logic                out_ovf;
    logic                ovf_sticky;
    logic                ovf_clear;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W:0] got_q[$];

    always #5 clk = ~clk;

    fixed_point_mac_pipe #(
        .WIDTH (W),
        .FRAC  (F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_addend  (in_addend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clear  (ovf_clear)
    );

    // Record every output transfer in delivery order
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_ovf, out_result});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] add);
        int   guard;
        logic rdy;
        guard     = 0;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_a      = a;
        in_b      = b;
        in_addend = add;
        do begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            guard++;
        end while (!rdy && guard < 100);
        if (!rdy) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 100) begin
            tick();
            guard++;
        end
        check("result_count", got_q.size(), n);
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] res, input logic ovf);
        logic [W:0] g;
        if (got_q.size() == 0) begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            g = got_q.pop_front();
            check({tag, "_res"}, g[W-1:0], res);
            check({tag, "_ovf"}, g[W], ovf);
        end
    endtask

    initial begin
        int         cyc;
        int         acc;
        logic [W-1:0] ba;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_addend = '0;
        out_ready = 1'b1;
        ovf_clear = 1'b0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Basic multiply and latency
        send(1'b0, 16'd192, 16'd256, 16'd0);
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("mul_latency", cyc, 3);
        wait_results(1);
        expect_res("mul_1p5x2", 16'd384, 1'b0);

        // Rounding
        send(1'b0, 16'd1, 16'd64, 16'd0);
        send(1'b0, 16'hFFFF, 16'd64, 16'd0);
        send(1'b0, 16'd1, 16'd63, 16'd0);
        wait_results(3);
        expect_res("rnd_half_up", 16'd1, 1'b0);
        expect_res("rnd_neg_half", 16'd0, 1'b0);
        expect_res("rnd_below_half", 16'd0, 1'b0);
        check("sticky_still_clear", ovf_sticky, 0);

        // Saturation
        send(1'b0, 16'h7FFF, 16'd256, 16'd0);
        send(1'b0, 16'h8000, 16'd256, 16'd0);
        send(1'b0, 16'h8000, 16'd128, 16'd0);
        wait_results(3);
        expect_res("sat_pos", 16'h7FFF, 1'b1);
        expect_res("sat_neg", 16'h8000, 1'b1);
        expect_res("min_exact", 16'h8000, 1'b0);
        tick();
        check("sticky_set", ovf_sticky, 1);

        // Multiply-accumulate
        send(1'b1, 16'd128, 16'd128, 16'd384);
        send(1'b1, 16'd256, 16'd256, 16'h7F00);
        send(1'b0, 16'd256, 16'd256, 16'h7F00);
        wait_results(3);
        expect_res("mac_basic", 16'd512, 1'b0);
        expect_res("mac_sat", 16'h7FFF, 1'b1);
        expect_res("mul_ignores_addend", 16'd512, 1'b0);

        // Backpressure: six back-to-back beats, out_ready low in cycles 2..7
        got_q.delete();
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 2 && c <= 7);
            if (acc < 6) begin
                ba        = 16'((acc + 1) * 128 + acc);
                in_valid  = 1'b1;
                in_mode   = 1'b0;
                in_a      = ba;
                in_b      = 16'd256;
                in_addend = 16'd0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 2) check("bp_ready_third", in_ready, 1);
            if (c == 3) check("bp_ready_full", in_ready, 0);
            if (c >= 3 && c <= 7) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_result", out_result, 16'd256);
            end
            if (in_valid && in_ready) acc++;
            if (c == 7) check("bp_accepted_stalled", acc, 3);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) expect_res("bp_order", 16'(2 * ((i + 1) * 128 + i)), 1'b0);

        // Reset with beats in flight
        got_q.delete();
        out_ready = 1'b0;
        send(1'b0, 16'd128, 16'd128, 16'd0);
        send(1'b0, 16'd256, 16'd128, 16'd0);
        send(1'b0, 16'd384, 16'd128, 16'd0);
        check("pre_rst_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_sticky", ovf_sticky, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send(1'b0, 16'd640, 16'd256, 16'd0);
        wait_results(1);
        repeat (5) tick();
        check("rst_no_stale", got_q.size(), 1);
        expect_res("post_rst", 16'd1280, 1'b0);

        // Sticky clear racing a saturating transfer
        send(1'b0, 16'h7FFF, 16'd256, 16'd0);
        wait_results(1);
        expect_res("clr_setup", 16'h7FFF, 1'b1);
        tick();
        check("clr_setup_sticky", ovf_sticky, 1);
        out_ready = 1'b0;
        send(1'b0, 16'h7FFF, 16'd256, 16'd0);
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("clr_stalled_valid", out_valid, 1);
        out_ready = 1'b1;
        ovf_clear = 1'b1;
        tick();
        check("clr_priority", ovf_sticky, 0);
        check("clr_transferred", out_valid, 0);
        ovf_clear = 1'b0;
        tick();
        check("clr_stays", ovf_sticky, 0);
        expect_res("clr_result", 16'h7FFF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
